cla_gp_stage: RTL and testbench
===============================

# cla_gp_stage

Registered generate/propagate front end of the carry-lookahead adder. It accepts operand pairs with carry-in over a valid/ready handshake and computes per-bit generate/propagate and per-4-bit group generate/propagate. Results are buffered in a 2-entry output queue. Downstream carry-generate cells (first-bit carry, group carries) and the sum stage consume `g`, `p`, `c0`, `gg` and `pg` directly from the queue head.

## Interface
- `N`, default 16: operand width in bits; must be a multiple of 4 and at least 4.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream has an operand set on `a`, `b`, `cin`.
- `in_ready`  out  1  block can accept an operand set this cycle.
- `a`  in  N  operand A.
- `b`  in  N  operand B.
- `cin`  in  1  carry into bit 0.
- `out_valid`  out  1  queue head holds a valid result.
- `out_ready`  in  1  downstream consumes the head this cycle.
- `g`  out  N  per-bit generate, `a & b`.
- `p`  out  N  per-bit propagate, `a ^ b` (XOR form, so sum = `p ^ carry` downstream).
- `c0`  out  1  registered `cin`; the carry input to the first-bit carry cell.
- `gg`  out  N/4  group generate, one bit per 4-bit group.
- `pg`  out  N/4  group propagate, one bit per 4-bit group.

## Operation
- Per bit i: `g[i] = a[i] & b[i]`, `p[i] = a[i] ^ b[i]`.
- Per group k, covering bits 4k..4k+3 (j = 4k):
  - `gg[k] = g[j+3] | p[j+3]g[j+2] | p[j+3]p[j+2]g[j+1] | p[j+3]p[j+2]p[j+1]g[j]`
  - `pg[k] = p[j+3] & p[j+2] & p[j+1] & p[j]`
- All computation happens on the input side. Each queue entry stores {g, p, c0, gg, pg}, i.e. 2N + 2·(N/4) + 1 bits. Outputs are driven only from queue registers, with no combinational path from `a`/`b`/`cin`.
- Queue state:
  - `count` ∈ {0, 1, 2}.
  - 1-bit write pointer and 1-bit read pointer; both wrap 1→0.
- Push = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- `in_ready = (count != 2) & ~rst`. `out_valid = (count != 0)`.
- Count update:
  - push only: count+1.
  - pop only: count−1.
  - push and pop together: count unchanged, pointers both advance. This is legal at count 1; at count 0 no pop can occur; at count 2 no push can occur.
- Data stays in order; no entry is dropped or duplicated.
- The head data (`g`, `p`, `c0`, `gg`, `pg`) holds stable while `out_valid & ~out_ready`.
- `a`, `b`, `cin` are don't-care when `in_valid` is 0.

## Timing
- Reset: `rst` high at an edge clears count and both pointers, and zeroes all stored entries.
  - From the following cycle: `out_valid=0`, `in_ready=1`, and `g`, `p`, `gg`, `pg`, `c0` are all 0.
  - While `rst` is high: `in_ready=0`.
- Reset mid-operation: any queued entries are discarded. A push or pop attempted in the reset cycle has no effect.
- Latency: an operand set accepted at edge t appears at the head with `out_valid=1` in cycle t+1 if the queue was empty. Otherwise it appears after the older entry pops.
- Throughput: one result per cycle with `out_ready` held high.
- Full: after two pushes with no pop, `in_ready=0` starting the cycle after the second push. It returns to 1 the cycle after the first pop.
- Empty with `in_valid=1`: no bypass; result is visible one cycle later.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid=1` → `out_valid=0`, `in_ready=0` during reset; `in_ready=1` and all outputs 0 the cycle after release.
- Mixed operands: N=16, `a=0x00FF`, `b=0x0F0F`, `cin=1`, `out_ready=1` → next cycle `g=0x000F`, `p=0x0FF0`, `c0=1`, `gg=4'b0001`, `pg=4'b0110`.
- Long-propagate case: `a=0xFFFF`, `b=0x0001`, `cin=0` → `g=0x0001`, `p=0xFFFE`, `c0=0`, `gg=4'b0001`, `pg=4'b1110`.
- Backpressure: `out_ready=0`, offer 3 sets X, Y, Z → X and Y accepted, `in_ready=0` after Y, Z held. Then raise `out_ready` → outputs appear in order X, Y, Z, and head values stay constant while stalled.
- Streaming: 20 random operand sets back-to-back with `out_ready=1` → one result per cycle, each matching the reference g/p/gg/pg model, count never exceeds 1.
- Reset with full queue: fill 2 entries, pulse `rst` with `out_ready=1` → no pop observed, `out_valid=0` next cycle, previously queued data never appears.

Source files
------------

// File: rtl/cla_gp_stage.sv
// Registered generate/propagate front end of the carry-lookahead adder.
// Computes bit and 4-bit group g/p on the input side and buffers results in a 2-entry queue.
module cla_gp_stage #(
    parameter int unsigned N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     g,
    output logic [N-1:0]     p,
    output logic             c0,
    output logic [N/4-1:0]   gg,
    output logic [N/4-1:0]   pg
);

    localparam int unsigned G = N / 4;
    localparam int unsigned W = 2 * N + 2 * G + 1;

    logic [N-1:0] g_in;
    logic [N-1:0] p_in;
    logic [G-1:0] gg_in;
    logic [G-1:0] pg_in;
    logic [W-1:0] entry_in;

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         push;
    logic         pop;
    logic [W-1:0] head;

    always_comb begin
        g_in = a & b;
        p_in = a ^ b;
        gg_in = '0;
        pg_in = '0;
        for (int unsigned k = 0; k < G; k++) begin
            gg_in[k] = g_in[4*k+3]
                     | (p_in[4*k+3] & g_in[4*k+2])
                     | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
                     | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
            pg_in[k] = &p_in[4*k +: 4];
        end
        entry_in = {g_in, p_in, cin, gg_in, pg_in};
    end

    // Handshake; rst forces in_ready low so nothing is pushed during the reset cycle.
    always_comb begin
        in_ready  = (count_q != 2'd2) & ~rst;
        out_valid = (count_q != 2'd0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = entry_in;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Outputs come straight from queue storage; no path from a/b/cin.
    always_comb begin
        head = mem_q[rd_ptr_q];
        {g, p, c0, gg, pg} = head;
    end

endmodule

// File: tb/tb_cla_gp_stage.sv
// Scoreboard bench for cla_gp_stage: directed reset/operand/backpressure cases plus random streaming.
module tb_cla_gp_stage;

    localparam int N = 16;
    localparam int G = N / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  g;
    logic [N-1:0]  p;
    logic          c0;
    logic [G-1:0]  gg;
    logic [G-1:0]  pg;

    typedef struct packed {
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic         c0;
        logic [G-1:0] gg;
        logic [G-1:0] pg;
    } res_t;

    res_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    cla_gp_stage #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .g         (g),
        .p         (p),
        .c0        (c0),
        .gg        (gg),
        .pg        (pg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Group generate is the carry out of a 4-bit add; group propagate is an all-ones XOR.
    function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
        res_t r;
        logic [4:0] s;
        r.g  = x & y;
        r.p  = x ^ y;
        r.c0 = ci;
        for (int k = 0; k < G; k++) begin
            s        = {1'b0, x[4*k +: 4]} + {1'b0, y[4*k +: 4]};
            r.gg[k]  = s[4];
            r.pg[k]  = ((x[4*k +: 4] ^ y[4*k +: 4]) == 4'hF);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("head", {g, p, c0, gg, pg}, e);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick();
        check({tag, "_drained"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_empty"}, {63'd0, out_valid}, 64'd0);
    endtask

    res_t x_r;
    res_t w_r;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 16'h1234;
        b         = 16'h4321;
        cin       = 1'b1;

        // Reset held two cycles with in_valid asserted
        tick();
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_rst_data", {g, p, c0, gg, pg}, 64'd0);

        // Mixed operands
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 16'h00FF; b = 16'h0F0F; cin = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("mix_valid", {63'd0, out_valid}, 64'd1);
        check("mix_g", g, 64'h000F);
        check("mix_p", p, 64'h0FF0);
        check("mix_c0", c0, 64'd1);
        check("mix_gg", gg, 64'b0001);
        check("mix_pg", pg, 64'b0110);

        // Long-propagate operands
        tick();
        in_valid = 1'b1;
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("lp_g", g, 64'h0001);
        check("lp_p", p, 64'hFFFE);
        check("lp_c0", c0, 64'd0);
        check("lp_gg", gg, 64'b0001);
        check("lp_pg", pg, 64'b1110);
        drain("lp");

        // Backpressure: X, Y accepted, Z held until a slot frees
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1;
        x_r = model(a, b, cin);
        tick();
        a = 16'h8001; b = 16'h8001; cin = 1'b0;
        tick();
        a = 16'h7777; b = 16'h1111; cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_full", {63'd0, in_ready}, 64'd0);
            check("bp_stall_head", {g, p, c0, gg, pg}, x_r);
            tick();
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_ready_after_pop", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        drain("bp");

        // Streaming: one result per cycle, queue never fills
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stream_in_ready", {63'd0, in_ready}, 64'd1);
            if (i > 0) check("stream_out_valid", {63'd0, out_valid}, 64'd1);
            tick();
        end
        in_valid = 1'b0;
        drain("stream");

        // Reset with a full queue: queued data must never appear
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
        tick();
        a = 16'hCAFE; b = 16'hF00D; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_data", {g, p, c0, gg, pg}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        tick();
        in_valid = 1'b1;
        a = 16'h0F0F; b = 16'h0FF0; cin = 1'b0;
        w_r = model(a, b, cin);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_head", {g, p, c0, gg, pg}, w_r);
        drain("flush");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
